// File: rtl/rot_cmd_feeder_amisha.sv
// ---------------------------------------------------------------------------
// rot_cmd_feeder_amisha
//
// Command front-end for an external 8-bit combinational rotate-right shifter.
// Rotate commands arrive on a valid/ready stream and are buffered in a small
// FIFO. A three-state controller (IDLE -> EXEC -> HOLD) takes one command at
// a time, drives the shifter's data/amount inputs from registers, captures
// the shifter result and presents it on a valid/ready output stream.
// A sweep command produces eight results, one for each amount 0..7, and
// marks only the final one with out_last.
//
// Parameters:
//   DEPTH            command FIFO entries (power of 2, >= 2)
//
// Ports:
//   clk_amisha       in   clock, rising edge
//   rst_n_amisha     in   asynchronous active-low reset
//   in_valid_amisha  in   command valid
//   in_ready_amisha  out  command accepted when valid && ready
//   in_data_amisha   in   [7:0] byte to rotate
//   in_amt_amisha    in   [2:0] rotate amount (ignored for sweep)
//   in_sweep_amisha  in   1 = sweep amounts 0..7
//   sh_a_amisha      out  [7:0] shifter data input (registered)
//   sh_amt_amisha    out  [2:0] shifter amount input (registered)
//   sh_y_amisha      in   [7:0] shifter result (combinational)
//   out_valid_amisha out  result valid
//   out_ready_amisha in   downstream ready
//   out_data_amisha  out  [7:0] rotated byte
//   out_amt_amisha   out  [2:0] amount used for out_data
//   out_last_amisha  out  final result of a command
//   done_cnt_amisha  out  [15:0] completed-handshake counter
//                         (present only when ROT_CNT_EN is defined)
//
// Build options:
//   ROT_CNT_EN       when defined, adds done_cnt_amisha, a wrapping 16-bit
//                    count of out_valid && out_ready handshakes.
// ---------------------------------------------------------------------------
module rot_cmd_feeder_amisha #(
    parameter int DEPTH = 4
) (
    input  logic        clk_amisha,
    input  logic        rst_n_amisha,
    input  logic        in_valid_amisha,
    output logic        in_ready_amisha,
    input  logic [7:0]  in_data_amisha,
    input  logic [2:0]  in_amt_amisha,
    input  logic        in_sweep_amisha,
    output logic [7:0]  sh_a_amisha,
    output logic [2:0]  sh_amt_amisha,
    input  logic [7:0]  sh_y_amisha,
    output logic        out_valid_amisha,
    input  logic        out_ready_amisha,
    output logic [7:0]  out_data_amisha,
    output logic [2:0]  out_amt_amisha,
    output logic        out_last_amisha
`ifdef ROT_CNT_EN
    ,
    output logic [15:0] done_cnt_amisha
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic       sweep;
        logic [2:0] amt;
        logic [7:0] data;
    } cmd_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_HOLD
    } state_t;

    // -----------------------------------------------------------------------
    // Command FIFO
    // -----------------------------------------------------------------------
    cmd_t            r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    state_t          r_state;
    logic            r_sweep;

    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    cmd_t            w_head;
    cmd_t            w_in_cmd;

    assign w_full   = (r_count == CW'(DEPTH));
    assign w_empty  = (r_count == '0);

    // Held low during reset so no command can slip in while state is cleared.
    assign in_ready_amisha = rst_n_amisha && !w_full;

    assign w_push   = in_valid_amisha && in_ready_amisha;
    // The controller only takes a new command when it is idle.
    assign w_pop    = (r_state == S_IDLE) && !w_empty;

    assign w_in_cmd = '{sweep: in_sweep_amisha, amt: in_amt_amisha, data: in_data_amisha};
    assign w_head   = r_mem[r_rd_ptr];

    // NOTE: the storage array carries no reset; occupancy and pointers define
    // which entries are meaningful, so clearing the payload would only cost
    // reset fan-out.
    always_ff @(posedge clk_amisha) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_in_cmd;
        end
    end

    // NOTE: all state registers use non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    always_ff @(posedge clk_amisha or negedge rst_n_amisha) begin
        if (!rst_n_amisha) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // DEPTH is a power of 2, so natural pointer overflow wraps modulo DEPTH.
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Controller: IDLE loads the shifter inputs, EXEC gives the combinational
    // shifter a full cycle before its result is captured, HOLD presents the
    // result until the downstream handshake.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_amisha or negedge rst_n_amisha) begin
        if (!rst_n_amisha) begin
            r_state          <= S_IDLE;
            r_sweep          <= 1'b0;
            sh_a_amisha      <= '0;
            sh_amt_amisha    <= '0;
            out_valid_amisha <= 1'b0;
            out_data_amisha  <= '0;
            out_amt_amisha   <= '0;
            out_last_amisha  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        sh_a_amisha   <= w_head.data;
                        // A sweep always starts at amount 0; its in_amt is ignored.
                        sh_amt_amisha <= w_head.sweep ? 3'd0 : w_head.amt;
                        r_sweep       <= w_head.sweep;
                        r_state       <= S_EXEC;
                    end
                end

                S_EXEC: begin
                    out_data_amisha  <= sh_y_amisha;
                    out_amt_amisha   <= sh_amt_amisha;
                    out_last_amisha  <= !r_sweep || (sh_amt_amisha == 3'd7);
                    out_valid_amisha <= 1'b1;
                    r_state          <= S_HOLD;
                end

                S_HOLD: begin
                    if (out_ready_amisha) begin
                        out_valid_amisha <= 1'b0;
                        if (r_sweep && (sh_amt_amisha != 3'd7)) begin
                            sh_amt_amisha <= sh_amt_amisha + 3'd1;
                            r_state       <= S_EXEC;
                        end else begin
                            r_state       <= S_IDLE;
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef ROT_CNT_EN
    // -----------------------------------------------------------------------
    // Handshake counter; wraps naturally at 16 bits.
    // -----------------------------------------------------------------------
    logic [15:0] r_done_cnt;

    always_ff @(posedge clk_amisha or negedge rst_n_amisha) begin
        if (!rst_n_amisha) begin
            r_done_cnt <= '0;
        end else if (out_valid_amisha && out_ready_amisha) begin
            r_done_cnt <= r_done_cnt + 16'd1;
        end
    end

    assign done_cnt_amisha = r_done_cnt;
`endif

endmodule

// File: tb/tb_rot_cmd_feeder_amisha.sv
// ---------------------------------------------------------------------------
// tb_rot_cmd_feeder_amisha
//
// Directed bench for rot_cmd_feeder_amisha. Includes a behavioural 8-bit
// rotate-right shifter driven by the DUT's sh_a/sh_amt outputs. Inputs are
// driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_rot_cmd_feeder_amisha;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [2:0]  in_amt;
    logic        in_sweep;
    logic [7:0]  sh_a;
    logic [2:0]  sh_amt;
    logic [7:0]  sh_y;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [2:0]  out_amt;
    logic        out_last;
`ifdef ROT_CNT_EN
    logic [15:0] done_cnt;
`endif

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int n_hs    = 0;

    rot_cmd_feeder_amisha #(.DEPTH(4)) dut (
        .clk_amisha       (clk),
        .rst_n_amisha     (rst_n),
        .in_valid_amisha  (in_valid),
        .in_ready_amisha  (in_ready),
        .in_data_amisha   (in_data),
        .in_amt_amisha    (in_amt),
        .in_sweep_amisha  (in_sweep),
        .sh_a_amisha      (sh_a),
        .sh_amt_amisha    (sh_amt),
        .sh_y_amisha      (sh_y),
        .out_valid_amisha (out_valid),
        .out_ready_amisha (out_ready),
        .out_data_amisha  (out_data),
        .out_amt_amisha   (out_amt),
        .out_last_amisha  (out_last)
`ifdef ROT_CNT_EN
        ,
        .done_cnt_amisha  (done_cnt)
`endif
    );

    // External combinational rotate-right shifter.
    logic [15:0] w_dbl;
    assign w_dbl = {sh_a, sh_a} >> sh_amt;
    assign sh_y  = w_dbl[7:0];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && out_valid && out_ready) n_hs++;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) until out_valid is high at a falling edge.
    task automatic wait_valid(input string tag);
        int i;
        i = 0;
        while (out_valid !== 1'b1 && i < 40) begin
            @(negedge clk);
            i++;
        end
        if (out_valid !== 1'b1) check({tag, "_timeout"}, 16'(out_valid), 16'd1);
    endtask

    // Presents one command for a single cycle (called at a falling edge).
    task automatic push(input logic [7:0] d, input logic [2:0] a, input logic s);
        in_valid = 1'b1;
        in_data  = d;
        in_amt   = a;
        in_sweep = s;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    logic [7:0] sweep_exp [8];
    int         acc;
    int         seen_valid;

    initial begin
        sweep_exp[0] = 8'h01; sweep_exp[1] = 8'h80; sweep_exp[2] = 8'h40; sweep_exp[3] = 8'h20;
        sweep_exp[4] = 8'h10; sweep_exp[5] = 8'h08; sweep_exp[6] = 8'h04; sweep_exp[7] = 8'h02;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_amt    = '0;
        in_sweep  = 1'b0;
        out_ready = 1'b0;

        // ---- reset state ----
        #1;
        check("rst_in_ready",  16'(in_ready),  16'd0);
        check("rst_out_valid", 16'(out_valid), 16'd0);
        check("rst_out_data",  16'(out_data),  16'd0);
        check("rst_out_amt",   16'(out_amt),   16'd0);
        check("rst_out_last",  16'(out_last),  16'd0);
        check("rst_sh_a",      16'(sh_a),      16'd0);
        check("rst_sh_amt",    16'(sh_amt),    16'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", 16'(in_ready), 16'd1);

        // ---- single rotate: 0x81 ror 1 = 0xC0, valid two edges after accept ----
        out_ready = 1'b1;
        push(8'h81, 3'd1, 1'b0);
        check("single_n0_valid", 16'(out_valid), 16'd0);
        @(negedge clk);
        check("single_n1_valid", 16'(out_valid), 16'd0);
        check("single_sh_a",     16'(sh_a),      16'h81);
        check("single_sh_amt",   16'(sh_amt),    16'd1);
        @(negedge clk);
        check("single_n2_valid", 16'(out_valid), 16'd1);
        check("single_data",     16'(out_data),  16'hC0);
        check("single_amt",      16'(out_amt),   16'd1);
        check("single_last",     16'(out_last),  16'd1);
        @(negedge clk);
        check("single_done_valid", 16'(out_valid), 16'd0);
        check("single_hs",         16'(n_hs),      16'd1);

        // ---- sweep of 0x01; in_amt must be ignored ----
        push(8'h01, 3'd5, 1'b1);
        for (int k = 0; k < 8; k++) begin
            wait_valid("sweep");
            check($sformatf("sweep%0d_data", k), 16'(out_data), 16'(sweep_exp[k]));
            check($sformatf("sweep%0d_amt", k),  16'(out_amt),  16'(k));
            check($sformatf("sweep%0d_last", k), 16'(out_last), (k == 7) ? 16'd1 : 16'd0);
            check($sformatf("sweep%0d_sh_a", k), 16'(sh_a),     16'h01);
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        check("sweep_idle_valid", 16'(out_valid), 16'd0);
        check("sweep_hs",         16'(n_hs),      16'd9);

        // ---- backpressure: 0xA5 ror 4 = 0x5A held for 5 stalled cycles ----
        out_ready = 1'b0;
        push(8'hA5, 3'd4, 1'b0);
        wait_valid("bp");
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_hold%0d_valid", i), 16'(out_valid), 16'd1);
            check($sformatf("bp_hold%0d_data", i),  16'(out_data),  16'h5A);
            check($sformatf("bp_hold%0d_amt", i),   16'(out_amt),   16'd4);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", 16'(out_valid), 16'd0);
        repeat (5) @(negedge clk);
        check("bp_hs", 16'(n_hs), 16'd10);

        // ---- FIFO full: data 0x01 with amounts 0,1,2,... while stalled ----
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h01;
        in_sweep  = 1'b0;
        acc       = 0;
        for (int i = 0; i < 10; i++) begin
            in_amt = 3'(acc);
            if (in_ready) acc++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("full_accepted", 16'(acc),      16'd5);
        check("full_in_ready", 16'(in_ready), 16'd0);
        check("full_r0_valid", 16'(out_valid), 16'd1);
        check("full_r0_data",  16'(out_data),  16'h01);
        check("full_r0_amt",   16'(out_amt),   16'd0);
        out_ready = 1'b1;
        @(negedge clk);
        check("full_after_hs_ready", 16'(in_ready), 16'd0);
        @(negedge clk);
        check("full_after_pop_ready", 16'(in_ready), 16'd1);
        for (int k = 1; k < 5; k++) begin
            wait_valid("full");
            check($sformatf("full_r%0d_data", k), 16'(out_data), 16'(sweep_exp[k]));
            check($sformatf("full_r%0d_amt", k),  16'(out_amt),  16'(k));
            check($sformatf("full_r%0d_last", k), 16'(out_last), 16'd1);
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        check("full_hs", 16'(n_hs), 16'd15);

        // ---- reset during the third sweep result ----
        push(8'h01, 3'd0, 1'b1);
        wait_valid("rs0");
        @(negedge clk);
        wait_valid("rs1");
        @(negedge clk);
        wait_valid("rs2");
        check("rs_third_data", 16'(out_data), 16'h40);
        rst_n = 1'b0;
        #1;
        check("rs_valid",    16'(out_valid), 16'd0);
        check("rs_data",     16'(out_data),  16'd0);
        check("rs_amt",      16'(out_amt),   16'd0);
        check("rs_last",     16'(out_last),  16'd0);
        check("rs_sh_a",     16'(sh_a),      16'd0);
        check("rs_sh_amt",   16'(sh_amt),    16'd0);
        check("rs_in_ready", 16'(in_ready),  16'd0);
        @(negedge clk);
        rst_n      = 1'b1;
        seen_valid = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen_valid++;
        end
        check("rs_quiet_after_release", 16'(seen_valid), 16'd0);
        check("rs_in_ready_after",      16'(in_ready),   16'd1);

        // ---- post-reset single: 0x81 ror 7 = 0x03 ----
        push(8'h81, 3'd7, 1'b0);
        wait_valid("post");
        check("post_data", 16'(out_data), 16'h03);
        check("post_amt",  16'(out_amt),  16'd7);
        check("post_last", 16'(out_last), 16'd1);
        @(negedge clk);
        check("post_valid_clear", 16'(out_valid), 16'd0);
`ifdef ROT_CNT_EN
        check("cnt_after_reset", done_cnt, 16'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rot_cmd_feeder_amisha.md
Name: rot_cmd_feeder_amisha

Overview:
- Command front-end for the 8-bit combinational rotate-right shifter.
- Accepts rotate commands over a valid/ready stream and buffers them in a small FIFO.
- Drives the shifter's data and amount inputs from registers, captures the shifter's result, and presents it on a valid/ready output stream.
- Supports single rotates and 8-step sweep commands (amounts 0..7).

Parameters:
DEPTH, 4, command FIFO entries; must be a power of 2, ≥2.

Ports:
clk_amisha  input  1  clock, rising edge.
rst_n_amisha  input  1  asynchronous active-low reset.
in_valid_amisha  input  1  command valid.
in_ready_amisha  output  1  command accepted when valid&&ready.
in_data_amisha  input  8  byte to rotate.
in_amt_amisha  input  3  rotate amount (ignored for sweep).
in_sweep_amisha  input  1  1 = sweep amounts 0..7.
sh_a_amisha  output  8  to shifter data input, registered.
sh_amt_amisha  output  3  to shifter amount input, registered.
sh_y_amisha  input  8  shifter result, combinational from sh_a/sh_amt.
out_valid_amisha  output  1  result valid.
out_ready_amisha  input  1  downstream ready.
out_data_amisha  output  8  rotated byte.
out_amt_amisha  output  3  amount used for out_data.
out_last_amisha  output  1  final result of a command (always 1 for single).

Behaviour:
- Reset (async assert, sync-to-clock deassert use only): FIFO empty, state IDLE. All registered outputs (sh_a, sh_amt, out_data, out_amt, out_valid, out_last) = 0. in_ready = 0 while reset is low.
- FIFO:
  - 12-bit entries {sweep, amt, data}; occupancy counter width clog2(DEPTH)+1.
  - in_ready = !full.
  - Push on in_valid&&in_ready.
  - Pop only in IDLE when not empty.
  - Push and pop in the same cycle: occupancy unchanged. Read/write pointers wrap modulo DEPTH.
- FSM states IDLE, EXEC, HOLD:
  - IDLE: if FIFO not empty, pop the head; load sh_a = data and sh_amt = sweep ? 0 : amt; latch the sweep flag; go EXEC.
  - EXEC (one cycle; shifter inputs stable): capture out_data = sh_y, out_amt = sh_amt, out_last = !sweep || sh_amt==7; set out_valid = 1; go HOLD.
  - HOLD:
    - out_valid stays 1; out_data, out_amt and out_last are held while out_ready = 0.
    - On out_ready: clear out_valid. If sweep and sh_amt≠7, increment sh_amt and go EXEC; otherwise go IDLE.
- Timing:
  - Command accepted at edge N with FIFO empty and state IDLE: pop at edge N+1, out_valid high after edge N+2.
  - Single command occupies at least 3 cycles; sweep occupies at least 1 + 2×8 = 17 cycles.
- sh_a is constant for the whole command; sh_amt changes only on IDLE→EXEC and HOLD→EXEC transitions.
- Inputs arriving while the FSM is busy are buffered. With out_ready held 0, exactly DEPTH+1 commands are accepted (one in flight plus DEPTH buffered), after which in_ready = 0.
- Reset mid-command: the in-flight command and FIFO contents are discarded; no partial result is emitted after reset release.
- The in_amt value of a sweep command is ignored.

Optional Feature:
ROT_CNT_EN:
- Defined: adds output port done_cnt_amisha [15:0], reset to 0. It increments on every out_valid&&out_ready handshake (8 per sweep) and wraps 0xFFFF→0x0000.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Single rotate: in_data=0x81, amt=1, out_ready=1 → one result out_data=0xC0, out_amt=1, out_last=1; out_valid rises 2 cycles after the accept edge.
- Sweep: in_data=0x01, sweep=1, out_ready=1 → out_data sequence 0x01,0x80,0x40,0x20,0x10,0x08,0x04,0x02 with out_amt 0..7; out_last only on the 8th.
- Backpressure: command 0xA5 amt 4, out_ready=0 for 5 cycles then 1 → out_data=0x5A held stable with out_valid=1 throughout; exactly one handshake.
- FIFO full: out_ready=0, in_valid=1 continuously, DEPTH=4 → 5 commands accepted then in_ready=0. Releasing out_ready: in_ready returns to 1 the cycle after the next pop; results come out in order.
- Reset mid-sweep: assert rst_n_amisha=0 during the 3rd sweep result → all outputs 0 immediately. After release with no new input, out_valid stays 0 for 20 cycles.
- ROT_CNT_EN: 8193 sweeps (65544 handshakes) → done_cnt_amisha = 8 after wrap.
